// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t STOP   = 3'd3;
  localparam state_t PARITY = 3'd4;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// Reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rx_uart.sv
// UART receiver, 16x oversampled, LSB first, 1 start / DBIT data / stop.
// Define RX_PARITY_EN to add a parity bit and the o_parity_err output.
module rx_uart
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
`ifdef RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  localparam logic [4:0] MID_S   = 5'(MID_TICK);
  localparam logic [4:0] LAST_S  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_S  = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_N  = 3'(DBIT - 1);
`ifdef RX_PARITY_EN
  localparam state_t     AFTER_D = PARITY;
`else
  localparam state_t     AFTER_D = STOP;
`endif

  logic            w_rx_s;
  state_t          r_state;
  logic [4:0]      r_s;
  logic [2:0]      r_n;
  logic [DBIT-1:0] r_shift;
  logic [DBIT-1:0] r_data;
  logic            r_done;
  logic            r_ferr;
`ifdef RX_PARITY_EN
  logic            r_par;
  logic            r_perr;
`endif

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (r_s == MID_S) begin
              // a start bit still low at mid-bit is real; else it was a glitch
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (r_s == LAST_S) begin
              r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
              r_s     <= '0;
              if (r_n == LAST_N) begin
                r_state <= AFTER_D;
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (i_s_tick) begin
            if (r_s == LAST_S) begin
              r_par   <= w_rx_s;
              r_s     <= '0;
              r_state <= STOP;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (i_s_tick) begin
            if (r_s == STOP_S) begin
              r_data  <= r_shift;
              r_ferr  <= ~w_rx_s;
              r_done  <= 1'b1;
`ifdef RX_PARITY_EN
              r_perr  <= ^r_shift ^ r_par ^ PARITY_ODD;
`endif
              r_state <= IDLE;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data         = r_data;
  assign o_rx_done_tick = r_done;
  assign o_frame_err    = r_ferr;
`ifdef RX_PARITY_EN
  assign o_parity_err   = r_perr;
`endif

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
- UART receiver that pairs with the existing transmitter.
- Samples the serial line using the shared 16x oversampling tick and recovers DBIT-bit frames, LSB first: 1 start bit, DBIT data bits, 1 stop bit.
- Presents each received byte with a single-cycle done strobe and a framing-error flag to the downstream consumer (FIFO or interface FSM).

Parameters:
- DBIT, 8: number of data bits per frame.
- SB_TICK, 16: oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_ODD, 0: parity sense when RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- i_clock  input  1  system clock; all registers on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_rx  input  1  serial line, asynchronous to i_clock; idles high.
- i_s_tick  input  1  oversampling strobe, one cycle wide, 16 per bit period.
- o_data  output  DBIT  last received word; held until the next frame completes.
- o_rx_done_tick  output  1  one-cycle pulse when a frame completes.
- o_frame_err  output  1  stop bit sampled low on the last completed frame; valid with and after o_rx_done_tick.

Behaviour:
- Reset (i_reset low, asynchronous): state=IDLE, s=0, n=0, shift register=0, o_data=0, o_rx_done_tick=0, o_frame_err=0, synchronizer flops=1.
- Reset mid-frame aborts the frame with no done pulse. The first valid start after release is received normally.
- i_rx passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s, giving 2 cycles of input latency.
- s is a 5-bit tick counter and n a 3-bit bit counter. Both are sized so that SB_TICK up to 32 and DBIT up to 8 do not wrap.
- State machine; the counter s advances only on i_s_tick:
  - IDLE: when rx_s==0 → START, s=0. A tick is not required to leave IDLE.
  - START: on each tick, if s==7 (mid start bit): rx_s==0 → DATA, s=0, n=0. rx_s==1 → IDLE (false start or glitch rejected, no pulse). Otherwise s++.
  - DATA: on each tick, if s==15: shift = {rx_s, shift[DBIT-1:1]}, s=0. If n==DBIT-1 → STOP (or PARITY when enabled), else n++. Otherwise s++.
  - STOP: on each tick, if s==SB_TICK-1: o_data=shift, o_frame_err=~rx_s, o_rx_done_tick=1 for exactly one cycle, → IDLE. Otherwise s++.
- Sampling point: every bit is sampled 16 ticks after the previous one, i.e. at mid-bit.
- o_rx_done_tick is registered and rises the cycle after the final stop tick.
- o_data and o_frame_err are registered and update in the same cycle the pulse is high. Both hold until the next completed frame.
- A framing error still produces a done pulse and updates o_data; the consumer decides whether to discard the byte.
- i_s_tick is ignored in IDLE.
- i_rx low held continuously (break condition): each frame completes with o_data=0 and o_frame_err=1. The FSM then re-enters START immediately.
- Back-to-back frames: a new start bit is detected in the first cycle after returning to IDLE, with no dead time required.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, with 16 ticks sampled at s==15.
  - Adds output port o_parity_err (1 bit, reset 0). It is set to (XOR of data bits XOR rx_s XOR PARITY_ODD) != 0 and updated alongside o_data.
- Undefined: no PARITY state and no o_parity_err port; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/START/DATA/STOP/PARITY, 3-bit state type;
  - OVERSAMPLE=16 and MID_TICK=7 constants, used by both rx_uart and tx_uart.
- One natural sub-module: sync_2ff (generic 2-flop synchronizer, reset value parameterised to 1). It is reused later for other asynchronous inputs.

Test Plan:
- Tick every 4 clocks; send 0xA5 with a valid stop bit → one o_rx_done_tick, o_data=0xA5, o_frame_err=0, pulse 2 cycles + 16*4*(1+8+1)−(8*4) clocks after the falling start edge, within ±4 clocks.
- 3-tick low glitch on idle line → FSM returns to IDLE, no pulse, o_data unchanged (0x00 after reset).
- Send 0x3C with stop bit forced low → pulse with o_data=0x3C, o_frame_err=1. Next frame 0x5A with valid stop → o_frame_err=0.
- Assert i_reset low during data bit 4 of 0xFF → outputs 0 asynchronously, no pulse. Release, send 0x81 → o_data=0x81.
- Back-to-back 0x00, 0xFF, 0x55 with zero idle gap → exactly three pulses, values in order, no errors.
- With RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 1 → o_parity_err=0. 0x07 with parity bit 0 → o_parity_err=1.
